// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants for the hazard scoreboard: default widths, producer latency
// encodings and the hard-wired zero register index.
package hazard_scoreboard_unit_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int DEF_LAT_W  = 3;

    localparam logic [DEF_LAT_W-1:0]  LAT_ALU  = 3'd0;
    localparam logic [DEF_LAT_W-1:0]  LAT_LOAD = 3'd1;
    localparam logic [DEF_LAT_W-1:0]  LAT_MD   = 3'd4;

    localparam logic [DEF_REG_AW-1:0] X0_IDX   = 5'd0;

endpackage

// File: rtl/hazard_scoreboard_unit_sb_counter_bank.sv
// Bank of per-register countdown counters. Each one holds the number of cycles
// until its pending producer result can be forwarded; x0 is permanently zero.
module sb_counter_bank #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_en,
    input  logic [REG_AW-1:0]         load_idx,
    input  logic [LAT_W-1:0]          load_val,
    output logic [NUM_REGS*LAT_W-1:0] cnt_flat
);

    assign cnt_flat[LAT_W-1:0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        logic [LAT_W-1:0] cnt_q;

        // NOTE: the bank is a handful of flops, not RAM, so every entry is reset;
        // a stale count after reset would stall or fail to stall the first consumer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (load_en && load_idx == REG_AW'(i)) begin
                cnt_q <= load_val;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - LAT_W'(1);
            end
        end

        assign cnt_flat[i*LAT_W +: LAT_W] = cnt_q;
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-side hazard unit: scoreboard-based RAW/WAW/structural stall detection,
// control-transfer bubbling and a stall-cycle performance counter.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NUM_REGS         = 32,
    parameter int REG_AW           = DEF_REG_AW,
    parameter int LAT_W            = DEF_LAT_W,
    parameter bit FLUSH_TAKEN_ONLY = 1'b0,
    parameter int PERF_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_id,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              reg_write_id,
    input  logic [LAT_W-1:0]  lat_id,
    input  logic              branch_id,
    input  logic              jal_id,
    input  logic              jalr_id,
    input  logic              pc_src_id,
    input  logic              md_op_id,
    input  logic              md_busy,
    output logic              stall_if,
    output logic              bubble_if,
    output logic              stall_id,
    output logic              bubble_id,
    output logic              stall_ex,
    output logic              bubble_ex,
    output logic              stall_mem,
    output logic              bubble_mem,
    output logic              stall_wb,
    output logic              bubble_wb,
    output logic [PERF_W-1:0] stall_cycles
);

    logic [NUM_REGS*LAT_W-1:0] cnt_flat;
    logic [LAT_W-1:0]          cnt_rs1, cnt_rs2, cnt_rd;
    logic [LAT_W:0]            lat_ext;
    logic [LAT_W-1:0]          load_val;
    logic                      id_res, raw1, raw2, waw, structural;
    logic                      stall, issue, load_en, ctl;

    assign cnt_rs1 = cnt_flat[rs1_id*LAT_W +: LAT_W];
    assign cnt_rs2 = cnt_flat[rs2_id*LAT_W +: LAT_W];
    assign cnt_rd  = cnt_flat[rd_id*LAT_W +: LAT_W];

    // Countdown starts at latency+1 so the issuing cycle itself is accounted for.
    assign lat_ext  = {1'b0, lat_id} + (LAT_W+1)'(1);
    assign load_val = lat_ext[LAT_W] ? '1 : lat_ext[LAT_W-1:0];

    // Branches and jalr resolve in ID and cannot use the EX-stage forward path.
    assign id_res = branch_id | jalr_id;

    assign raw1 = rs1_used_id && (rs1_id != X0_IDX) &&
                  (id_res ? (cnt_rs1 != '0) : (cnt_rs1 > LAT_W'(1)));
    assign raw2 = rs2_used_id && (rs2_id != X0_IDX) &&
                  (id_res ? (cnt_rs2 != '0) : (cnt_rs2 > LAT_W'(1)));
    assign waw        = reg_write_id && (rd_id != X0_IDX) && ({1'b0, cnt_rd} > lat_ext);
    assign structural = md_op_id & md_busy;

    assign stall   = rst_n & valid_id & (raw1 | raw2 | waw | structural);
    assign issue   = valid_id & ~stall;
    assign load_en = issue & reg_write_id & (rd_id != X0_IDX);

    assign ctl = FLUSH_TAKEN_ONLY ? pc_src_id : (jal_id | id_res);

    assign stall_if   = stall;
    assign stall_id   = stall;
    assign bubble_ex  = stall;
    assign bubble_id  = rst_n & valid_id & ctl & ~stall;
    assign bubble_if  = 1'b0;
    assign stall_ex   = 1'b0;
    assign stall_mem  = 1'b0;
    assign bubble_mem = 1'b0;
    assign stall_wb   = 1'b0;
    assign bubble_wb  = 1'b0;

    sb_counter_bank #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .LAT_W    (LAT_W)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .load_idx (rd_id),
        .load_val (load_val),
        .cnt_flat (cnt_flat)
    );

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: both flush modes share one
// stimulus stream; expected values are hand-derived cycle counts.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_id;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       rs1_used_id, rs2_used_id, reg_write_id;
    logic [2:0] lat_id;
    logic       branch_id, jal_id, jalr_id, pc_src_id, md_op_id, md_busy;

    logic        stall_if, bubble_if, stall_id, bubble_id, stall_ex, bubble_ex;
    logic        stall_mem, bubble_mem, stall_wb, bubble_wb;
    logic [31:0] stall_cycles;
    logic        t_stall_if, t_bubble_if, t_stall_id, t_bubble_id, t_stall_ex, t_bubble_ex;
    logic        t_stall_mem, t_bubble_mem, t_stall_wb, t_bubble_wb;
    logic [31:0] t_stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.FLUSH_TAKEN_ONLY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .lat_id(lat_id),
        .branch_id(branch_id), .jal_id(jal_id), .jalr_id(jalr_id), .pc_src_id(pc_src_id),
        .md_op_id(md_op_id), .md_busy(md_busy),
        .stall_if(stall_if), .bubble_if(bubble_if), .stall_id(stall_id), .bubble_id(bubble_id),
        .stall_ex(stall_ex), .bubble_ex(bubble_ex), .stall_mem(stall_mem), .bubble_mem(bubble_mem),
        .stall_wb(stall_wb), .bubble_wb(bubble_wb), .stall_cycles(stall_cycles)
    );

    hazard_scoreboard_unit #(.FLUSH_TAKEN_ONLY(1'b1)) dut_t (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .lat_id(lat_id),
        .branch_id(branch_id), .jal_id(jal_id), .jalr_id(jalr_id), .pc_src_id(pc_src_id),
        .md_op_id(md_op_id), .md_busy(md_busy),
        .stall_if(t_stall_if), .bubble_if(t_bubble_if), .stall_id(t_stall_id), .bubble_id(t_bubble_id),
        .stall_ex(t_stall_ex), .bubble_ex(t_bubble_ex), .stall_mem(t_stall_mem), .bubble_mem(t_bubble_mem),
        .stall_wb(t_stall_wb), .bubble_wb(t_bubble_wb), .stall_cycles(t_stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_id = 1'b0; rs1_id = '0; rs2_id = '0; rd_id = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; reg_write_id = 1'b0; lat_id = '0;
        branch_id = 1'b0; jal_id = 1'b0; jalr_id = 1'b0; pc_src_id = 1'b0;
        md_op_id = 1'b0; md_busy = 1'b0;
        #1;
    endtask

    // One ID-stage instruction; control/md fields default to 0 via idle().
    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we,
                         input logic [2:0] lat, input logic br, input logic pc);
        idle();
        valid_id = 1'b1; rs1_id = rs1; rs1_used_id = u1; rs2_id = rs2; rs2_used_id = u2;
        rd_id = rd; reg_write_id = we; lat_id = lat; branch_id = br; pc_src_id = pc;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("reset_ctl", {22'd0, stall_if, bubble_if, stall_id, bubble_id, stall_ex,
                            bubble_ex, stall_mem, bubble_mem, stall_wb, bubble_wb}, 32'd0);
        check("reset_perf", stall_cycles, 32'd0);

        // Reset asserted while a load-use stall is pending on x5 (cnt[5]=2)
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("pre_reset_stall", stall_id, 32'd1);
        rst_n = 1'b0;
        #1;
        check("in_reset_ctl", {22'd0, stall_if, bubble_if, stall_id, bubble_id, stall_ex,
                               bubble_ex, stall_mem, bubble_mem, stall_wb, bubble_wb}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_reset_no_stall", stall_id, 32'd0);
        check("post_reset_perf", stall_cycles, 32'd0);
        tick();

        // ALU -> ALU consumer: forwarded, no stall
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 3'd0, 1'b0, 1'b0);
        check("alu_alu_stall", stall_id, 32'd0);
        check("alu_alu_bubble_ex", bubble_ex, 32'd0);
        tick();

        // ALU -> beq: one stall, then bubble on issue (not taken)
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        instr(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        check("alu_beq_stall", {stall_if, stall_id, bubble_ex, bubble_id}, 32'b1110);
        check("alu_beq_t_bubble", t_bubble_id, 32'd0);
        tick();
        check("alu_beq_issue", {stall_id, bubble_id}, 32'b01);
        check("alu_beq_nt_t_bubble", t_bubble_id, 32'd0);
        tick();

        // Load-use: one stall cycle
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd1, 1'b0, 1'b0);
        check("lw_issue", stall_id, 32'd0);
        tick();
        instr(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("load_use_stall", {stall_id, bubble_ex}, 32'b11);
        tick();
        check("load_use_release", stall_id, 32'd0);
        check("load_use_perf", stall_cycles, 32'd2);
        tick();

        // Load -> taken beq on rs2: two stalls, then bubble in both modes
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        instr(5'd0, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1);
        check("lw_beq_stall1", {stall_id, bubble_id, t_bubble_id}, 32'b100);
        tick();
        check("lw_beq_stall2", stall_id, 32'd1);
        tick();
        check("lw_beq_issue", {stall_id, bubble_id, t_bubble_id}, 32'b011);
        tick();

        // mul x7 lat 4 -> add x7: four stalls
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd4, 1'b0, 1'b0);
        md_op_id = 1'b1;
        #1;
        tick();
        instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mul_raw_stall%0d", i), stall_id, 32'd1);
            tick();
        end
        check("mul_raw_release", stall_id, 32'd0);
        tick();

        // Structural: mul/div busy for three cycles
        idle();
        valid_id = 1'b1; md_op_id = 1'b1; md_busy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("md_busy_stall%0d", i), stall_id, 32'd1);
            tick();
        end
        md_busy = 1'b0;
        #1;
        check("md_busy_release", stall_id, 32'd0);
        tick();

        // WAW: add x7 right behind mul x7 lat 4
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd4, 1'b0, 1'b0);
        md_op_id = 1'b1;
        #1;
        tick();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("waw_stall%0d", i), stall_id, 32'd1);
            tick();
        end
        check("waw_release", stall_id, 32'd0);
        check("waw_perf", stall_cycles, 32'd15);
        tick();

        // x0 is never tracked and never a hazard source
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        check("x0_beq_stall", stall_id, 32'd0);
        tick();

        // Unused rs2 matching a pending load
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        instr(5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("unused_rs2_stall", stall_id, 32'd0);
        tick();

        // Latency 7 saturates the count at 7: six stalls for a normal consumer
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd7, 1'b0, 1'b0);
        md_op_id = 1'b1;
        #1;
        tick();
        instr(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("sat_stall%0d", i), stall_id, 32'd1);
            tick();
        end
        check("sat_release", stall_id, 32'd0);
        tick();

        // jal bubbles in both modes (always taken)
        idle();
        valid_id = 1'b1; jal_id = 1'b1; pc_src_id = 1'b1;
        #1;
        check("jal_bubble", {stall_id, bubble_id, t_bubble_id}, 32'b011);
        check("fixed_zero_ctl", {bubble_if, stall_ex, stall_mem, bubble_mem, stall_wb, bubble_wb}, 32'd0);
        tick();
        idle();
        check("idle_ctl", {stall_id, bubble_id, bubble_ex}, 32'd0);
        check("final_perf", stall_cycles, 32'd21);
        check("final_perf_t", t_stall_cycles, 32'd21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
